dbus_mmio_responder: RTL

Responder on the RV32I core's data-memory port. Sits between the core's data bus (daddr, ddata_w, d_rw, ddata_r) and the data RAM. It claims a 256-byte memory-mapped I/O window and passes every other access through to the RAM. Inside the window it serves a 64-bit cycle timer with compare interrupt and a byte console FIFO drained by an external sink (the bench monitor).

---
 rtl/dbus_mmio_responder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/dbus_mmio_responder.sv
// RV32I data-bus responder: claims a 256-byte MMIO window, forwards everything else to data RAM.
// Latency: reads are combinational (0 cycles); writes land on the rising edge with d_rw = 1.
// Backpressure: the console FIFO drains on con_valid & con_ready; a push into a full FIFO with no pop is dropped and sets overflow.
// Optional timer (mtime / mtimecmp / irq_timer) is built only when MMIO_TIMER_EN is defined.
module dbus_mmio_responder #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [23:0] MMIO_BASE  = 24'hFFFFFF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] daddr,
    input  logic [31:0] ddata_w,
    input  logic        d_rw,
    input  logic [31:0] ram_dout,
    output logic        ram_we,
    output logic [31:0] ddata_r,
    output logic [7:0]  con_data,
    output logic        con_valid,
    input  logic        con_ready,
    output logic        irq_timer
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [5:0] OFF_MTIME_LO  = 6'd0;
    localparam logic [5:0] OFF_MTIME_HI  = 6'd1;
    localparam logic [5:0] OFF_MTCMP_LO  = 6'd2;
    localparam logic [5:0] OFF_MTCMP_HI  = 6'd3;
    localparam logic [5:0] OFF_CON_TX    = 6'd4;
    localparam logic [5:0] OFF_CON_COUNT = 6'd5;

    logic          w_hit;
    logic [5:0]    w_off;
    logic          w_wr;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push_req;
    logic          w_push;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic [31:0]   w_mmio_rdata;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    // Byte lanes are not decoded; only word offsets inside the window matter.
    assign w_hit = (daddr[31:8] == MMIO_BASE);
    assign w_off = daddr[7:2];
    assign w_wr  = d_rw & w_hit;

    assign ram_we  = d_rw & ~w_hit;
    assign ddata_r = w_hit ? w_mmio_rdata : ram_dout;

    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_pop      = ~w_empty & con_ready;
    assign w_push_req = w_wr & (w_off == OFF_CON_TX);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_ovf_set  = w_push_req & w_full & ~w_pop;
    assign w_ovf_clr  = w_wr & (w_off == OFF_CON_COUNT);

    assign con_valid = ~w_empty;
    assign con_data  = w_empty ? 8'h00 : r_mem[r_rptr];

    // FIFO storage: contents are don't-care until pushed, so no reset.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= ddata_w[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_ovf_set)      r_ovf <= 1'b1;
            else if (w_ovf_clr) r_ovf <= 1'b0;
        end
    end

`ifdef MMIO_TIMER_EN
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_irq;
    logic        w_unused_ok;

    assign w_unused_ok = ^daddr[1:0];

    // Free-running 64-bit timer, compare register and registered compare interrupt.
    // The compare uses the pre-increment mtime and the pre-write mtimecmp.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_mtime    <= 64'd0;
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_irq      <= 1'b0;
        end else begin
            r_mtime <= r_mtime + 64'd1;
            r_irq   <= (r_mtime >= r_mtimecmp);
            if (w_wr && (w_off == OFF_MTCMP_LO)) r_mtimecmp[31:0]  <= ddata_w;
            if (w_wr && (w_off == OFF_MTCMP_HI)) r_mtimecmp[63:32] <= ddata_w;
        end
    end

    assign irq_timer = r_irq;
`else
    logic w_unused_ok;

    assign w_unused_ok = ^{daddr[1:0], ddata_w[31:8]};
    assign irq_timer   = 1'b0;
`endif

    // MMIO read mux; unmapped offsets (and the timer block when absent) read zero.
    always_comb begin
        w_mmio_rdata = 32'd0;
        case (w_off)
`ifdef MMIO_TIMER_EN
            OFF_MTIME_LO:  w_mmio_rdata = r_mtime[31:0];
            OFF_MTIME_HI:  w_mmio_rdata = r_mtime[63:32];
            OFF_MTCMP_LO:  w_mmio_rdata = r_mtimecmp[31:0];
            OFF_MTCMP_HI:  w_mmio_rdata = r_mtimecmp[63:32];
`else
            OFF_MTIME_LO,
            OFF_MTIME_HI,
            OFF_MTCMP_LO,
            OFF_MTCMP_HI:  w_mmio_rdata = 32'd0;
`endif
            OFF_CON_TX:    w_mmio_rdata = {29'd0, r_ovf, w_full, w_empty};
            OFF_CON_COUNT: w_mmio_rdata = {{(32-CW){1'b0}}, r_count};
            default:       w_mmio_rdata = 32'd0;
        endcase
    end

endmodule
